// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (port 0)
// and the branch/compare unit (port 1), with registered operands and registered results.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [OP_WIDTH-1:0]   req1_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [3:0]            rsp_flags,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_carryout,
    input  logic                  alu_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  owner_q, owner_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]            rsp_flags_q, rsp_flags_d;
    logic                  any_valid;
    logic                  grant;
    logic                  rsp_done;

    function automatic logic is_illegal(input logic [OP_WIDTH-1:0] op);
        logic legal;
        legal = (op == OP_WIDTH'(4'b0000)) || (op == OP_WIDTH'(4'b0001)) ||
                (op == OP_WIDTH'(4'b0010)) || (op == OP_WIDTH'(4'b0110)) ||
                (op == OP_WIDTH'(4'b0111)) || (op == OP_WIDTH'(4'b0100)) ||
                (op == OP_WIDTH'(4'b0011));
        return !legal;
    endfunction

    // A lone requester always wins; a tie goes to the port named by prio.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? prio_q : req1_valid;
    end

    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state_q == IDLE) && req1_valid && grant;
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp_done   = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        illegal_d    = illegal_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    alu_a_d   = grant ? req1_a : req0_a;
                    alu_b_d   = grant ? req1_b : req0_b;
                    alu_op_d  = grant ? req1_op : req0_op;
                    illegal_d = is_illegal(grant ? req1_op : req0_op);
                    owner_d   = grant;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = {illegal_q, alu_overflow, alu_carryout, alu_zero};
                state_d      = RESP;
            end
            RESP: begin
                // Priority passes to the other port only once a result has been consumed.
                if (rsp_done) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            illegal_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            illegal_q    <= illegal_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_arbiter;
    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_overflow, alu_carryout, alu_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: one operation in flight at most.
    bit          m_busy;
    int          m_age;
    bit          m_owner;
    bit          m_prio;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op, m_flags;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_carryout(alu_carryout), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {overflow, carryout, zero, result}; unknown opcodes give 0.
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov, co;
        r  = '0;
        ov = 1'b0;
        co = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                r  = a - b;
                co = (a < b);
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0100: r = (a < b) ? 32'd1 : 32'd0;
            4'b0011: r = {b[15:0], 16'h0000};
            default: r = '0;
        endcase
        return {ov, co, (r == 32'd0), r};
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h4, 4'h3};
    endfunction

    assign {alu_overflow, alu_carryout, alu_zero, alu_result} = alu_model(alu_a, alu_b, alu_op);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [3:0] op0, input bit v1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [3:0] op1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    endtask

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        bit          g;
        logic [34:0] f;
        if (rst) begin
            checkOutput("rst_req0_ready", req0_ready, 0);
            checkOutput("rst_req1_ready", req1_ready, 0);
            checkOutput("rst_rsp0_valid", rsp0_valid, 0);
            checkOutput("rst_rsp1_valid", rsp1_valid, 0);
            checkOutput("rst_rsp_result", rsp_result, 0);
            checkOutput("rst_rsp_flags", rsp_flags, 0);
            checkOutput("rst_alu_a", alu_a, 0);
            checkOutput("rst_alu_b", alu_b, 0);
            checkOutput("rst_alu_op", alu_op, 0);
            m_busy  = 0;
            m_age   = 0;
            m_owner = 0;
            m_prio  = 0;
        end else begin
            g = (req0_valid && req1_valid) ? m_prio : req1_valid;
            checkOutput("req0_ready", req0_ready, !m_busy && req0_valid && !g);
            checkOutput("req1_ready", req1_ready, !m_busy && req1_valid && g);
            checkOutput("rsp0_valid", rsp0_valid, m_busy && m_age >= 1 && !m_owner);
            checkOutput("rsp1_valid", rsp1_valid, m_busy && m_age >= 1 && m_owner);
            if (m_busy) begin
                checkOutput("alu_a", alu_a, m_a);
                checkOutput("alu_b", alu_b, m_b);
                checkOutput("alu_op", alu_op, m_op);
            end
            if (m_busy && m_age >= 1) begin
                checkOutput("rsp_result", rsp_result, m_res);
                checkOutput("rsp_flags", rsp_flags, m_flags);
            end
            if (!m_busy && (req0_valid || req1_valid)) begin
                m_busy  = 1;
                m_age   = 0;
                m_owner = g;
                m_a     = g ? req1_a : req0_a;
                m_b     = g ? req1_b : req0_b;
                m_op    = g ? req1_op : req0_op;
                f       = alu_model(m_a, m_b, m_op);
                m_res   = f[31:0];
                m_flags = {!op_legal(m_op), f[34], f[33], f[32]};
            end else if (m_busy) begin
                if (m_age >= 1 && (m_owner ? rsp1_ready : rsp0_ready)) begin
                    m_busy = 0;
                    m_prio = !m_owner;
                end else begin
                    m_age = 1;
                end
            end
        end
    end

    task automatic wait_ready(input bit port, output bit ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                ok = 1;
                return;
            end
        end
        ok = 0;
        checkOutput("ready_timeout", 0, 1);
    endtask

    // Issue one request on a port, check 2-cycle latency, accept the response at once.
    task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, output logic [31:0] res, output logic [3:0] flags);
        bit ok;
        if (port) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
        end
        wait_ready(port, ok);
        @(posedge clk); #1;
        if (port) begin
            req1_valid = 0; rsp1_ready = 1;
        end else begin
            req0_valid = 0; rsp0_ready = 1;
        end
        @(negedge clk);
        checkOutput("lat_exec_rsp_valid", port ? rsp1_valid : rsp0_valid, 0);
        @(negedge clk);
        checkOutput("lat_resp_rsp_valid", port ? rsp1_valid : rsp0_valid, 1);
        res   = rsp_result;
        flags = rsp_flags;
        @(posedge clk); #1;
        rsp0_ready = 0;
        rsp1_ready = 0;
    endtask

    function automatic logic [3:0] pick_op();
        logic [3:0] legal_ops [7];
        legal_ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h4, 4'h3};
        if ($urandom_range(0, 7) == 0) return 4'($urandom);
        return legal_ops[$urandom_range(0, 6)];
    endfunction

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 4));
        return $urandom;
    endfunction

    initial begin
        logic [31:0] res;
        logic [3:0]  flags;
        rst = 1;
        rsp0_ready = 0;
        rsp1_ready = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_result", rsp_result, 32'h0);
        checkOutput("reset_alu_a", alu_a, 32'h0);
        rst = 0;

        // Both ports valid straight out of reset: port 0 first, then port 1.
        applyStimulus(1, 5, 5, 4'b0110, 1, 1, 2, 4'b0100);
        @(negedge clk);
        checkOutput("dual_first_req0_ready", req0_ready, 1);
        checkOutput("dual_first_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0; rsp0_ready = 1;
        @(negedge clk);
        checkOutput("exec_blocks_req1", req1_ready, 0);
        @(negedge clk);
        checkOutput("sub_rsp0_valid", rsp0_valid, 1);
        checkOutput("sub_result", rsp_result, 32'h0);
        checkOutput("sub_zero_flag", rsp_flags[0], 1);
        @(posedge clk); #1;
        rsp0_ready = 0;
        @(negedge clk);
        checkOutput("dual_second_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0; rsp1_ready = 1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("sltu_rsp1_valid", rsp1_valid, 1);
        checkOutput("sltu_result", rsp_result, 32'h1);
        @(posedge clk); #1;
        rsp1_ready = 0;

        // Three back-to-back dual requests alternate owners 0,1,0.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 32'(k), 1, 4'b0010, 1, 32'h10, 32'h01, 4'b0001);
            @(negedge clk);
            checkOutput("alt_req0_ready", req0_ready, (k != 1));
            checkOutput("alt_req1_ready", req1_ready, (k == 1));
            @(posedge clk); #1;
            req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
            @(negedge clk);
            @(negedge clk);
            checkOutput("alt_result", rsp_result, (k == 1) ? 32'h11 : 32'(k + 1));
            @(posedge clk); #1;
            rsp0_ready = 0; rsp1_ready = 0;
        end

        run_op(0, 32'h7FFFFFFF, 32'h1, 4'b0010, res, flags);
        checkOutput("add_ovf_result", res, 32'h80000000);
        checkOutput("add_ovf_flags", flags, 4'b0100);

        // Port 1 result held under backpressure while port 0 waits; rsp0_ready is a non-owner.
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 4'b0010;
        @(negedge clk);
        checkOutput("bp_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        req0_valid = 1; req0_a = 32'hFF; req0_b = 32'h0F; req0_op = 4'b0000;
        rsp0_ready = 1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_rsp1_valid", rsp1_valid, 1);
            checkOutput("bp_result", rsp_result, 32'h7);
            checkOutput("bp_flags", rsp_flags, 4'b0000);
            checkOutput("bp_req0_ready", req0_ready, 0);
        end
        @(posedge clk); #1;
        rsp1_ready = 1; rsp0_ready = 0;
        @(negedge clk);
        checkOutput("bp_accept_req0_ready", req0_ready, 0);
        @(posedge clk); #1;
        rsp1_ready = 0;
        @(negedge clk);
        checkOutput("bp_after_req0_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0; rsp0_ready = 1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_port0_result", rsp_result, 32'h0F);
        @(posedge clk); #1;
        rsp0_ready = 0;

        run_op(1, 5, 3, 4'b1111, res, flags);
        checkOutput("illegal_flag", flags[3], 1);
        checkOutput("illegal_result", res, 32'h0);
        run_op(1, 1, 1, 4'b0010, res, flags);
        checkOutput("legal_clears_flag", flags[3], 0);
        checkOutput("legal_after_illegal_result", res, 32'h2);

        run_op(1, 0, 32'h0000ABCD, 4'b0011, res, flags);
        checkOutput("lui_result", res, 32'hABCD0000);
        checkOutput("lui_flags", flags, 4'b0000);
        applyStimulus(1, 9, 9, 4'b0001, 1, 8, 8, 4'b0001);
        @(negedge clk);
        checkOutput("lui_prio0_req0_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rsp0_ready = 0;

        // Reset during EXEC with prio at 1: no response, then port 0 wins the first tie.
        applyStimulus(1, 32'h20, 32'h22, 4'b0010, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rstexec_req0_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        #2;
        rst = 1;
        applyStimulus(1, 32'h30, 32'h1, 4'b0010, 1, 32'h40, 32'h1, 4'b0010);
        #1;
        checkOutput("async_rst_rsp0_valid", rsp0_valid, 0);
        checkOutput("async_rst_req0_ready", req0_ready, 0);
        checkOutput("async_rst_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checkOutput("post_rst_req0_ready", req0_ready, 1);
        checkOutput("post_rst_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_rst_result", rsp_result, 32'h31);
        @(posedge clk); #1;
        rsp0_ready = 0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 499) == 0);
            applyStimulus($urandom_range(0, 2) != 0, pick_operand(), pick_operand(), pick_op(),
                          $urandom_range(0, 2) != 0, pick_operand(), pick_operand(), pick_op());
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        rst = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rsp0_ready = 1;
        rsp1_ready = 1;
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
